// File: rtl/snn_frame_sequencer.sv
// -----------------------------------------------------------------------------
// snn_frame_sequencer
//
// Host-side controller for the three-layer spiking network core. Parses a
// byte-stream command protocol (valid/ready), loads weights into the core,
// keeps a shadow copy of the input spike vector, runs N execute ticks,
// counts output spikes per output neuron and reports the counts plus an
// argmax winner over a second valid/ready byte stream.
//
// Commands:
//   0x01 + WEIGHT_BYTES bytes : stream weights into the core
//   0x02 + INPUT_BYTES bytes  : load shadow input vector (first byte = MSB)
//   0x03 + N                  : run N ticks (N=0 means 256), then report
//   other                     : dropped, sets sticky err
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   s_valid/s_ready/s_data  command/payload byte stream in
//   m_valid/m_ready/m_data  report byte stream out (count[0] first)
//   snn_data                core data_in
//   snn_load_weights        core input_weights
//   snn_execute             core execute
//   snn_spikes              core output spikes
//   winner                  lowest index with maximum count (valid with m_valid)
//   busy                    FSM not idle
//   err                     sticky unknown-opcode flag
// -----------------------------------------------------------------------------
module snn_frame_sequencer #(
  parameter int INPUT_BYTES  = 2,
  parameter int WEIGHT_BYTES = 80,
  parameter int OUTPUTS      = 8,
  parameter int COUNT_BITS   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic [7:0]         snn_data,
  output logic               snn_load_weights,
  output logic               snn_execute,
  input  logic [OUTPUTS-1:0] snn_spikes,
  output logic [2:0]         winner,
  output logic               busy,
  output logic               err
);

  localparam int SH_W   = 8 * INPUT_BYTES;
  localparam int BC_MAX = (WEIGHT_BYTES > INPUT_BYTES) ? WEIGHT_BYTES : INPUT_BYTES;
  localparam int BC_W   = $clog2(BC_MAX + 1);
  localparam int RI_W   = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_I,
    ST_GET_N,
    ST_PRELOAD,
    ST_EXEC,
    ST_REPORT
  } state_t;

  state_t                              r_state;
  logic [BC_W-1:0]                     r_bcnt;
  logic [SH_W-1:0]                     r_shadow;
  logic [SH_W-1:0]                     r_pre;
  logic [7:0]                          r_left;
  logic                                r_exec_q;
  logic [OUTPUTS-1:0][COUNT_BITS-1:0]  r_cnt;
  logic [RI_W-1:0]                     r_rep_idx;
  logic                                r_m_valid;
  logic [7:0]                          r_m_data;
  logic [2:0]                          r_winner;
  logic                                r_err;
  logic [7:0]                          r_snn_data;
  logic                                r_snn_lw;
  logic                                r_snn_exec;

  logic                                w_s_ready;
  logic                                w_accept;
  logic [OUTPUTS-1:0][COUNT_BITS-1:0]  w_cnt_next;
  logic [COUNT_BITS-1:0]               w_best;
  logic [2:0]                          w_win;
  logic [RI_W-1:0]                     w_rep_nxt;

  assign w_s_ready = (r_state == ST_IDLE)   || (r_state == ST_LOAD_W) ||
                     (r_state == ST_LOAD_I) || (r_state == ST_GET_N);
  assign w_accept  = s_valid & w_s_ready;
  assign w_rep_nxt = r_rep_idx + RI_W'(1);

  // Spike samples land one cycle after each execute cycle, so the counters
  // advance whenever the previous cycle had execute asserted.
  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTS; gi++) begin : g_cnt
      assign w_cnt_next[gi] = (r_exec_q && snn_spikes[gi] && (r_cnt[gi] != CNT_MAX))
                              ? r_cnt[gi] + COUNT_BITS'(1) : r_cnt[gi];
    end
  endgenerate

  // Argmax over the post-sample counts so the winner is ready on the same
  // edge that raises m_valid. Strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best = w_cnt_next[0];
    w_win  = 3'd0;
    for (int i = 1; i < OUTPUTS; i++) begin
      if (w_cnt_next[i] > w_best) begin
        w_best = w_cnt_next[i];
        w_win  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bcnt     <= '0;
      r_shadow   <= '0;
      r_pre      <= '0;
      r_left     <= '0;
      r_exec_q   <= 1'b0;
      r_cnt      <= '0;
      r_rep_idx  <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_winner   <= '0;
      r_err      <= 1'b0;
      r_snn_data <= '0;
      r_snn_lw   <= 1'b0;
      r_snn_exec <= 1'b0;
    end else begin
      // Core strobes default low; the core shifts snn_data in whenever both
      // strobes are low, which is why PRELOAD always re-sends the shadow.
      r_snn_lw   <= 1'b0;
      r_snn_exec <= 1'b0;
      r_snn_data <= '0;
      r_exec_q   <= r_snn_exec;
      if (r_exec_q) begin
        r_cnt <= w_cnt_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bcnt <= '0;
            case (s_data)
              8'h01:   r_state <= ST_LOAD_W;
              8'h02:   r_state <= ST_LOAD_I;
              8'h03:   r_state <= ST_GET_N;
              default: r_err   <= 1'b1;
            endcase
          end
        end

        ST_LOAD_W: begin
          if (w_accept) begin
            r_snn_lw   <= 1'b1;
            r_snn_data <= s_data;
            if (r_bcnt == BC_W'(WEIGHT_BYTES - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_bcnt <= r_bcnt + BC_W'(1);
            end
          end
        end

        ST_LOAD_I: begin
          if (w_accept) begin
            // Shift left: the first byte ends up in the most significant slot.
            r_shadow <= (r_shadow << 8) | SH_W'(s_data);
            if (r_bcnt == BC_W'(INPUT_BYTES - 1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_bcnt <= r_bcnt + BC_W'(1);
            end
          end
        end

        ST_GET_N: begin
          if (w_accept) begin
            // r_left holds the execute cycles still to issue after the first;
            // the 8-bit wrap of 0-1 gives 255, i.e. 256 ticks for N=0.
            r_left     <= s_data - 8'd1;
            r_snn_data <= r_shadow[SH_W-1 -: 8];
            r_pre      <= r_shadow << 8;
            r_bcnt     <= BC_W'(1);
            r_cnt      <= '0;
            r_state    <= ST_PRELOAD;
          end
        end

        ST_PRELOAD: begin
          if (r_bcnt != BC_W'(INPUT_BYTES)) begin
            r_snn_data <= r_pre[SH_W-1 -: 8];
            r_pre      <= r_pre << 8;
            r_bcnt     <= r_bcnt + BC_W'(1);
          end else begin
            r_snn_exec <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (r_left != 8'd0) begin
            r_snn_exec <= 1'b1;
            r_left     <= r_left - 8'd1;
          end else if (!r_snn_exec) begin
            // This is the trailing sample cycle of the last execute tick.
            r_state   <= ST_REPORT;
            r_m_valid <= 1'b1;
            r_m_data  <= 8'(w_cnt_next[0]);
            r_winner  <= w_win;
            r_rep_idx <= '0;
          end
        end

        ST_REPORT: begin
          if (m_ready) begin
            if (r_rep_idx == RI_W'(OUTPUTS - 1)) begin
              r_m_valid <= 1'b0;
              r_m_data  <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_rep_idx <= w_rep_nxt;
              r_m_data  <= 8'(r_cnt[w_rep_nxt]);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready          = w_s_ready;
  assign busy             = (r_state != ST_IDLE);
  assign err              = r_err;
  assign m_valid          = r_m_valid;
  assign m_data           = r_m_data;
  assign winner           = r_winner;
  assign snn_data         = r_snn_data;
  assign snn_load_weights = r_snn_lw;
  assign snn_execute      = r_snn_exec;

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_frame_sequencer
//
// Directed bench for snn_frame_sequencer: reset state, weight streaming with
// gaps, a timed basic run with report back-pressure, N=0 saturation, unknown
// opcode handling and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_snn_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [7:0] snn_data;
  logic       snn_load_weights;
  logic       snn_execute;
  logic [7:0] snn_spikes;
  logic [2:0] winner;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int exec_total = 0;
  int lw_total = 0;

  snn_frame_sequencer #(
    .INPUT_BYTES (2),
    .WEIGHT_BYTES(80),
    .OUTPUTS     (8),
    .COUNT_BITS  (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .snn_data        (snn_data),
    .snn_load_weights(snn_load_weights),
    .snn_execute     (snn_execute),
    .snn_spikes      (snn_spikes),
    .winner          (winner),
    .busy            (busy),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snn_execute)      exec_total++;
    if (snn_load_weights) lw_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data  = 8'h00;
  endtask

  // Run command with exact timing checks on preload, execute and m_valid.
  task automatic do_run(input logic [7:0] n, input logic [7:0] d0, input logic [7:0] d1,
                        input int ticks);
    send(8'h03);
    send(n);
    @(negedge clk);
    check("preload0_data", 32'(snn_data), 32'(d0));
    check("preload0_exec", 32'(snn_execute), 32'd0);
    @(negedge clk);
    check("preload1_data", 32'(snn_data), 32'(d1));
    for (int k = 0; k < ticks; k++) begin
      @(negedge clk);
      check("exec_tick", 32'(snn_execute), 32'd1);
    end
    @(negedge clk);
    check("exec_end", 32'(snn_execute), 32'd0);
    check("mvalid_early", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("mvalid_rise", 32'(m_valid), 32'd1);
    $display("run N=%0d ticks=%0d done", n, ticks);
  endtask

  // Drain the report; byte i of exp sits in bits [8i+7:8i].
  task automatic read_report(input logic [63:0] exp, input logic [2:0] exp_win, input int hold_at);
    int n;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n = 0;
      while (!m_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("mvalid_timeout", 32'(m_valid), 32'd1);
      check("report_byte", 32'(m_data), 32'(exp[i*8 +: 8]));
      if (i == 0) check("winner", 32'(winner), 32'(exp_win));
      $display("report byte %0d = 0x%02h winner %0d", i, m_data, winner);
      if (i == hold_at) begin
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(exp[i*8 +: 8]));
        end
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
    @(negedge clk);
    check("report_done_mvalid", 32'(m_valid), 32'd0);
    check("report_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int lw_before;
    int ex_before;
    int gap;

    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    m_ready    = 1'b0;
    snn_spikes = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_snn", 32'({snn_data, snn_load_weights, snn_execute}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Weight load with random gaps
    lw_before = lw_total;
    send(8'h01);
    for (int i = 0; i < 80; i++) begin
      send(8'(i));
      @(negedge clk);
      check("lw_strobe", 32'(snn_load_weights), 32'd1);
      check("lw_data", 32'(snn_data), 32'(i));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
        check("lw_gap", 32'(snn_load_weights), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("lw_count", 32'(lw_total - lw_before), 32'd80);
    check("lw_idle_busy", 32'(busy), 32'd0);
    check("lw_idle_ready", 32'(s_ready), 32'd1);
    $display("weight load of 80 bytes done");

    // Basic run
    send(8'h02);
    send(8'hA5);
    send(8'h3C);
    snn_spikes = 8'hFF;
    do_run(8'h03, 8'hA5, 8'h3C, 3);
    read_report(64'h0303030303030303, 3'd0, 3);

    // Saturation with N=0
    snn_spikes = 8'h81;
    ex_before = exec_total;
    do_run(8'h00, 8'hA5, 8'h3C, 256);
    check("n0_exec_count", 32'(exec_total - ex_before), 32'd256);
    read_report(64'hFF000000000000FF, 3'd0, -1);

    // Unknown opcode
    send(8'h7E);
    @(negedge clk);
    check("unk_err", 32'(err), 32'd1);
    check("unk_busy", 32'(busy), 32'd0);
    check("unk_snn", 32'({snn_data, snn_load_weights, snn_execute}), 32'd0);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    check("unk_err_sticky", 32'(err), 32'd1);
    check("unk_load_busy", 32'(busy), 32'd0);
    snn_spikes = 8'h04;
    do_run(8'h01, 8'h11, 8'h22, 1);
    read_report(64'h0000000000010000, 3'd2, -1);

    // Reset in the middle of a 50-tick run
    snn_spikes = 8'h0F;
    send(8'h03);
    send(8'd50);
    @(negedge clk);
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) check("midexec_tick10", 32'(snn_execute), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_exec", 32'(snn_execute), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    snn_spikes = 8'h30;
    do_run(8'h01, 8'h00, 8'h00, 1);
    read_report(64'h0000010100000000, 3'd4, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snn_frame_sequencer.md
# snn_frame_sequencer

Host-side controller for the three-layer spiking network core. It accepts a byte-stream command protocol over a valid/ready handshake and drives the core's `data_in`, `input_weights` and `execute` pins. Its jobs are loading weights, holding a shadow copy of the input spike vector, running N timesteps, and counting output spikes per output neuron. At the end of a run it reports the counts plus an argmax winner. It sits between the host byte interface and the core; the core's `uio_in[1:0]` and `ui_in` are driven only by this block.

## Interface
- `INPUT_BYTES`, default 2: bytes in one input spike vector (16 inputs).
- `WEIGHT_BYTES`, default 80: bytes in a full weight load (640 weight bits).
- `OUTPUTS`, default 8: output neurons observed.
- `COUNT_BITS`, default 8: width of each spike counter; at most 8.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `s_valid`  in  1  command/payload byte valid.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `s_data`  in  8  command/payload byte.
- `m_valid`  out  1  report byte valid.
- `m_ready`  in  1  report byte consumed when `m_valid & m_ready`.
- `m_data`  out  8  report byte; the count is zero-extended.
- `snn_data`  out  8  drives core `data_in`.
- `snn_load_weights`  out  1  drives core `input_weights`.
- `snn_execute`  out  1  drives core `execute`.
- `snn_spikes`  in  OUTPUTS  core output spikes.
- `winner`  out  3  lowest index holding the maximum count; valid while `m_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky flag for an unknown opcode.

## Operation
- Opcodes:
  - 0x01: load weights, followed by WEIGHT_BYTES bytes.
  - 0x02: load inputs, followed by INPUT_BYTES bytes into the shadow register, first byte = most significant.
  - 0x03: run, followed by 1 byte N; N=0 means 256 ticks.
  - Any other opcode: dropped, sets `err`, FSM stays in IDLE.
- States: IDLE, LOAD_W, LOAD_I, GET_N, PRELOAD, EXEC, REPORT.
  - IDLE → LOAD_W / LOAD_I / GET_N on the matching opcode.
  - LOAD_W and LOAD_I → IDLE after their last payload byte.
  - GET_N → PRELOAD → EXEC → REPORT → IDLE.
- `s_ready` is 1 in IDLE, LOAD_W, LOAD_I and GET_N; 0 in every other state.
- All `snn_*` outputs are registered.
  - Default every cycle: `snn_execute`=0, `snn_load_weights`=0, `snn_data`=0.
  - While `snn_execute`=0 and `snn_load_weights`=0, the core shifts `snn_data` into its inputs every cycle. The live core inputs are therefore clobbered outside a run, and PRELOAD always re-sends the shadow copy.
- LOAD_W: each accepted payload byte produces exactly one cycle with `snn_load_weights`=1 and `snn_data`=byte. Gaps in `s_valid` produce cycles with both strobes 0.
- PRELOAD: INPUT_BYTES consecutive cycles, shadow bytes most-significant first, strobes 0. Clears all counters.
- EXEC: exactly N consecutive cycles with `snn_execute`=1.
  - `snn_spikes` is sampled on the cycle after each execute cycle, giving N samples.
  - Each set bit increments its counter; counters saturate at 2^COUNT_BITS−1.
- REPORT: OUTPUTS bytes, count[0] first.
  - Each byte is held stable until `m_ready`.
  - After the last byte is consumed, return to IDLE.
  - Counters and shadow are retained until the next run or reset.

## Timing
- Reset values:
  - FSM = IDLE, so `s_ready`=1.
  - `m_valid`=0, `m_data`=0, `winner`=0, `busy`=0, `err`=0.
  - All `snn_*` outputs = 0.
  - Shadow register = 0, counters = 0.
- Reset mid-operation aborts immediately. Outputs take their reset values on the cycle after `rst_n` is sampled low. No partial report is produced.
- Run timeline, with the N byte accepted in cycle t:
  - Preload bytes appear on `snn_data` at t+1 .. t+INPUT_BYTES.
  - `snn_execute`=1 at t+INPUT_BYTES+1 .. t+INPUT_BYTES+N.
  - Last spike sample at t+INPUT_BYTES+N+1.
  - `m_valid` rises at t+INPUT_BYTES+N+2.
- LOAD_W latency: strobe at cycle a+1 for a byte accepted at cycle a. Sustains 1 byte per cycle.
- A back-to-back opcode is accepted on the cycle after the last payload byte of the previous command.

## Test plan
- Reset: hold `rst_n` low 2 cycles → `s_ready`=1, `busy`=0, `err`=0, `m_valid`=0, all `snn_*` = 0.
- Weight load: 0x01 + 80 bytes (0x00..0x4F) with random `s_valid` gaps → exactly 80 `snn_load_weights` pulses, each one cycle after acceptance, `snn_data` matching in order; FSM back in IDLE.
- Basic run: 0x02,0xA5,0x3C then 0x03,0x03 with `snn_spikes`=0xFF:
  - `snn_data` = 0xA5 then 0x3C.
  - `snn_execute` high 3 consecutive cycles.
  - Report 8×0x03, `winner`=0.
  - Hold `m_ready` low 5 cycles mid-report → `m_data` stable.
- Saturation and N=0: 0x03,0x00 with `snn_spikes`=0x81 → 256 execute cycles, count[0]=count[7]=0xFF, others 0x00, `winner`=0.
- Unknown opcode: 0x7E → `err`=1, no `snn_*` activity. A following 0x02,0x11,0x22 is parsed correctly; `err` stays 1.
- Reset mid-EXEC: `rst_n` low for 1 cycle during tick 10 of N=50 → next cycle `snn_execute`=0, `busy`=0, `m_valid`=0. A subsequent run preloads 0x00,0x00.
